dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbitrates the single-port synchronous data memory of the pipelined `mips` core between two requesters. The MEM stage (cpu port) is one requester. The program/data loader used by benches and boot code (ldr port) is the other. The CPU has fixed priority, and a starvation counter guarantees the loader a slot. The block sits between the MEM stage and the `data_memory` array, and stalls the pipeline when the CPU loses arbitration.

## Interface
Parameters:
- `ADDR_W`, 10, word address width (1024-word data memory)
- `DATA_W`, 32, data word width
- `MAX_WAIT`, 4, contested cycles a waiting loader tolerates before it is forced to win; range 1..15

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `cpu_req`  in  1  MEM stage access request
- `cpu_we`  in  1  1 = store, 0 = load
- `cpu_addr`  in  ADDR_W  word address
- `cpu_wdata`  in  DATA_W  store data
- `cpu_gnt`  out  1  access issued this cycle (combinational)
- `cpu_stall`  out  1  `cpu_req & ~cpu_gnt`; freezes the pipeline
- `cpu_rvalid`  out  1  load data valid (registered, 1 cycle after the load grant)
- `cpu_rdata`  out  DATA_W  load data
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_gnt`, `ldr_rvalid`, `ldr_rdata`  same meaning for the loader port
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  memory read data, valid 1 cycle after a read strobe

## Operation
- Grant per cycle, combinational from the requests and `wait_cnt`:
  - only one port requesting: that port wins
  - both requesting: CPU wins unless `wait_cnt == MAX_WAIT`, in which case the loader wins
- The winner's `we`/`addr`/`wdata` are muxed onto `mem_*`, and `mem_en = cpu_gnt | ldr_gnt`. The two grants are never high together.
- `wait_cnt` (4 bits) behaviour:
  - increments when `ldr_req & ~ldr_gnt`
  - clears on `ldr_gnt`, or when `ldr_req` is low
  - saturates at `MAX_WAIT`
- Read return tracking: a registered owner tag, one of `OWN_NONE`, `OWN_CPU`, `OWN_LDR`.
  - Set to the granted port on a read grant; otherwise `OWN_NONE`.
  - Next cycle, the owner's `rvalid` is 1 and its `rdata = mem_rdata`.
  - The non-owner's `rdata` holds 0.
- Writes produce no `rvalid`.
- Requesters must hold req/we/addr/wdata stable until they are granted. The arbiter keeps no request buffer.
- Back-to-back grants to alternating ports are legal every cycle. Full throughput is 1 access per cycle.

## Timing
- Reset values:
  - `cpu_gnt`/`ldr_gnt` follow the requests combinationally (CPU priority, since `wait_cnt` = 0)
  - `cpu_rvalid` = `ldr_rvalid` = 0, `cpu_rdata` = `ldr_rdata` = 0
  - owner = `OWN_NONE`, `wait_cnt` = 0
  - `mem_*` are driven from the requests
- Read latency: grant in cycle N, `rvalid` in cycle N+1.
- Worst-case loader wait under continuous CPU traffic: granted on its (`MAX_WAIT`+1)-th requesting cycle. The CPU stalls exactly that one cycle.
- Simultaneous events:
  - A load granted in cycle N+1 does not disturb the N+1 return of the load granted in cycle N. The owner register is overwritten only after the N+1 return has been presented.
  - Same-address write by one port and read by the other in consecutive cycles: the read sees the written value (memory is write-first by the time of the next access).
- Reset asserted mid-access: a pending `rvalid` is dropped, no return is produced after release, and the counter restarts at 0.
- `ldr_req` dropped while waiting: `wait_cnt` clears that cycle.

## Structure
- A shared package `mips_pkg` holds:
  - the owner encoding `OWN_NONE`, `OWN_CPU`, `OWN_LDR` (2-bit)
  - the default `DATA_W`/`ADDR_W` constants used by `mips`
- One natural sub-module: `starve_counter`, a saturating counter with inc/clear/limit compare that outputs `force_ldr`.
- The rest is flat: the grant mux plus the owner/rdata registers.

## Test plan
- Reset with both requests high → `cpu_gnt`=1, `ldr_gnt`=0, both `rvalid`=0. Deassert reset → CPU load of addr 5 returns `cpu_rdata`=5 with `cpu_rvalid` one cycle later.
- Continuous `cpu_req` and `ldr_req`, `MAX_WAIT`=4 → `ldr_gnt` pulses on every 5th cycle, `cpu_stall`=1 on exactly those cycles, `wait_cnt` sequence 0,1,2,3,4,0.
- Loader writes 32'hDEAD_BEEF to addr 7, then the CPU reads addr 7 the next cycle → `cpu_rdata`=32'hDEAD_BEEF, `ldr_rvalid` never asserted.
- Alternating single-cycle reads: CPU addr 3, loader addr 9, CPU addr 4 → returns 3 (cpu), 9 (ldr), 4 (cpu) on consecutive cycles with no crossover.
- CPU load granted, reset asserted on the following edge → no `cpu_rvalid` after reset release, and the first post-reset grant goes to the CPU.
- Loader waits 3 cycles, then drops `ldr_req` for 1 cycle and re-asserts → the counter restarts, and the loader is granted only after 4 further contested cycles.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the mips core: default bus widths and the
// read-return owner encoding used by the data-memory arbiter.
package mips_pkg;

    localparam int MIPS_ADDR_W = 10;
    localparam int MIPS_DATA_W = 32;

    // Which requester the memory read data presented this cycle belongs to.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LDR  = 2'd2
    } owner_t;

endpackage

// File: rtl/dmem_arbiter_starve_counter.sv
// Loader starvation counter: counts contested cycles the loader has lost,
// saturates at LIMIT, and raises force_ldr once the limit is reached.
module starve_counter #(
    parameter int LIMIT = 4,
    parameter int CNT_W = 4
)(
    input  logic clk,
    input  logic reset,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_force_ldr
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] r_cnt;

    // Count lost cycles; clear wins over increment, hold at the limit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIMIT_C)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_force_ldr = (r_cnt == LIMIT_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the MEM stage (cpu) and the loader (ldr).
// Fixed CPU priority with a starvation guarantee for the loader; read
// returns are steered by a one-cycle owner tag registered at grant time.
module dmem_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W   = MIPS_ADDR_W,
    parameter int DATA_W   = MIPS_DATA_W,
    parameter int MAX_WAIT = 4
)(
    input  logic              clk,
    input  logic              reset,
    // MEM stage port
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    // Loader port
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    // Memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic   w_force_ldr;
    logic   w_cpu_gnt;
    logic   w_ldr_gnt;
    logic   w_ldr_inc;
    logic   w_ldr_clr;
    owner_t w_owner_p0;
    owner_t r_owner_p1;

    // Grant selection: CPU first, unless a waiting loader has hit its limit
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_ldr_gnt = 1'b0;
        if (cpu_req && ldr_req) begin
            if (w_force_ldr) begin
                w_ldr_gnt = 1'b1;
            end else begin
                w_cpu_gnt = 1'b1;
            end
        end else begin
            w_cpu_gnt = cpu_req;
            w_ldr_gnt = ldr_req;
        end
    end

    assign cpu_gnt   = w_cpu_gnt;
    assign ldr_gnt   = w_ldr_gnt;
    assign cpu_stall = cpu_req & ~w_cpu_gnt;

    // Memory command mux: the loader's fields only when it holds the grant
    always_comb begin
        mem_en    = w_cpu_gnt | w_ldr_gnt;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (w_ldr_gnt) begin
            mem_we    = ldr_we;
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
        end
    end

    // Tag the read issued this cycle with its requester; writes get no tag
    always_comb begin
        w_owner_p0 = OWN_NONE;
        if (w_cpu_gnt && !cpu_we) begin
            w_owner_p0 = OWN_CPU;
        end else if (w_ldr_gnt && !ldr_we) begin
            w_owner_p0 = OWN_LDR;
        end
    end

    // ---- stage boundary: grant -> read return ----
    // Owner tag register; reset drops any return still in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner_p1 <= OWN_NONE;
        end else begin
            r_owner_p1 <= w_owner_p0;
        end
    end

    // The memory data bus is shared, so the non-owner sees zeros
    assign cpu_rvalid = (r_owner_p1 == OWN_CPU);
    assign ldr_rvalid = (r_owner_p1 == OWN_LDR);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign ldr_rdata  = ldr_rvalid ? mem_rdata : '0;

    // A loader that is requesting but not granted is losing a contested cycle
    assign w_ldr_inc = ldr_req & ~w_ldr_gnt;
    assign w_ldr_clr = ~ldr_req | w_ldr_gnt;

    starve_counter #(
        .LIMIT (MAX_WAIT),
        .CNT_W (4)
    ) u_starve (
        .clk         (clk),
        .reset       (reset),
        .i_inc       (w_ldr_inc),
        .i_clr       (w_ldr_clr),
        .o_force_ldr (w_force_ldr)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed stimulus pushes expected read
// data per port; a negedge monitor pops and compares on every rvalid.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        cpu_req, cpu_we;
    logic [9:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        ldr_req, ldr_we;
    logic [9:0]  ldr_addr;
    logic [31:0] ldr_wdata;
    logic        ldr_gnt, ldr_rvalid;
    logic [31:0] ldr_rdata;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] cpu_q [$];
    logic [31:0] ldr_q [$];

    // Memory model: unwritten word i holds i
    logic [31:0] mem_arr [0:1023];
    bit          wr_flag [0:1023];

    dmem_arbiter #(
        .ADDR_W   (10),
        .DATA_W   (32),
        .MAX_WAIT (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_stall  (cpu_stall),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_gnt    (ldr_gnt),
        .ldr_rvalid (ldr_rvalid),
        .ldr_rdata  (ldr_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous write-first memory
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem_arr[mem_addr] <= mem_wdata;
                wr_flag[mem_addr] <= 1'b1;
            end else begin
                mem_rdata <= wr_flag[mem_addr] ? mem_arr[mem_addr] : 32'(mem_addr);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every return must match the oldest expectation of its port
    always @(negedge clk) begin
        if (cpu_rvalid) begin
            if (cpu_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL cpu_rvalid_unexpected: got rvalid=1 rdata=%h expected no return at %0t", cpu_rdata, $time);
            end else begin
                chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
            end
        end else begin
            chk("cpu_rdata_idle", cpu_rdata, 32'h0);
        end
        if (ldr_rvalid) begin
            if (ldr_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ldr_rvalid_unexpected: got rvalid=1 rdata=%h expected no return at %0t", ldr_rdata, $time);
            end else begin
                chk("ldr_rdata", ldr_rdata, ldr_q.pop_front());
            end
        end else begin
            chk("ldr_rdata_idle", ldr_rdata, 32'h0);
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 10'd0;
        cpu_wdata = 32'h0;
        ldr_req   = 1'b1;
        ldr_we    = 1'b0;
        ldr_addr  = 10'd0;
        ldr_wdata = 32'h0;

        // Reset state with both requests high
        step();
        step();
        #3;
        chk("rst_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("rst_ldr_gnt", 32'(ldr_gnt), 32'd0);
        chk("rst_cpu_stall", 32'(cpu_stall), 32'd0);
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
        chk("rst_wait_cnt", 32'(dut.u_starve.r_cnt), 32'd0);

        // First CPU load after reset: addr 5, one-cycle latency
        step();
        reset    = 1'b0;
        ldr_req  = 1'b0;
        cpu_addr = 10'd5;
        #3;
        chk("t1_cpu_gnt", 32'(cpu_gnt), 32'd1);
        cpu_q.push_back(32'd5);
        step();
        cpu_req = 1'b0;
        #3;
        chk("t1_rvalid_n1", 32'(cpu_rvalid), 32'd1);
        step();
        #3;
        chk("t1_rvalid_n2", 32'(cpu_rvalid), 32'd0);

        // Continuous contention: loader wins every 5th cycle
        step();
        cpu_req  = 1'b1;
        cpu_addr = 10'd10;
        ldr_req  = 1'b1;
        ldr_addr = 10'd20;
        for (int k = 0; k < 10; k++) begin
            #3;
            chk("t2_ldr_gnt", 32'(ldr_gnt), 32'((k % 5) == 4));
            chk("t2_cpu_gnt", 32'(cpu_gnt), 32'((k % 5) != 4));
            chk("t2_cpu_stall", 32'(cpu_stall), 32'((k % 5) == 4));
            chk("t2_wait_cnt", 32'(dut.u_starve.r_cnt), 32'(k % 5));
            if ((k % 5) == 4) ldr_q.push_back(32'd20);
            else              cpu_q.push_back(32'd10);
            step();
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        step();
        step();

        // Loader write then CPU read of the same word
        ldr_req   = 1'b1;
        ldr_we    = 1'b1;
        ldr_addr  = 10'd7;
        ldr_wdata = 32'hDEAD_BEEF;
        #3;
        chk("t3_ldr_gnt", 32'(ldr_gnt), 32'd1);
        chk("t3_mem_en", 32'(mem_en), 32'd1);
        chk("t3_mem_we", 32'(mem_we), 32'd1);
        chk("t3_mem_addr", 32'(mem_addr), 32'd7);
        chk("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        step();
        ldr_req  = 1'b0;
        ldr_we   = 1'b0;
        cpu_req  = 1'b1;
        cpu_addr = 10'd7;
        #3;
        chk("t3_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("t3_mem_we_rd", 32'(mem_we), 32'd0);
        cpu_q.push_back(32'hDEAD_BEEF);
        step();
        cpu_req = 1'b0;
        step();
        step();

        // Alternating single-cycle reads: cpu 3, ldr 9, cpu 4
        cpu_req  = 1'b1;
        cpu_addr = 10'd3;
        #3;
        chk("t4_cpu_gnt_a", 32'(cpu_gnt), 32'd1);
        cpu_q.push_back(32'd3);
        step();
        cpu_req  = 1'b0;
        ldr_req  = 1'b1;
        ldr_addr = 10'd9;
        #3;
        chk("t4_ldr_gnt", 32'(ldr_gnt), 32'd1);
        chk("t4_mem_addr", 32'(mem_addr), 32'd9);
        ldr_q.push_back(32'd9);
        step();
        ldr_req  = 1'b0;
        cpu_req  = 1'b1;
        cpu_addr = 10'd4;
        #3;
        chk("t4_cpu_gnt_b", 32'(cpu_gnt), 32'd1);
        chk("t4_ldr_rvalid", 32'(ldr_rvalid), 32'd1);
        cpu_q.push_back(32'd4);
        step();
        cpu_req = 1'b0;
        step();
        step();

        // CPU load granted, then reset on the next edge: return is dropped
        cpu_req  = 1'b1;
        cpu_addr = 10'd6;
        #3;
        chk("t5_cpu_gnt", 32'(cpu_gnt), 32'd1);
        step();
        cpu_req = 1'b0;
        reset   = 1'b1;
        #3;
        chk("t5_rvalid_in_rst", 32'(cpu_rvalid), 32'd0);
        step();
        cpu_req  = 1'b1;
        cpu_addr = 10'd8;
        ldr_req  = 1'b1;
        ldr_addr = 10'd13;
        step();
        reset = 1'b0;
        #3;
        chk("t5_post_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("t5_post_ldr_gnt", 32'(ldr_gnt), 32'd0);
        chk("t5_post_wait_cnt", 32'(dut.u_starve.r_cnt), 32'd0);
        chk("t5_post_rvalid", 32'(cpu_rvalid), 32'd0);
        cpu_q.push_back(32'd8);
        step();
        cpu_req = 1'b0;
        #3;
        chk("t5_ldr_gnt", 32'(ldr_gnt), 32'd1);
        ldr_q.push_back(32'd13);
        step();
        ldr_req = 1'b0;
        step();
        step();

        // Loader waits 3 cycles, drops for one, then needs 4 more contested cycles
        cpu_req  = 1'b1;
        cpu_addr = 10'd11;
        ldr_req  = 1'b1;
        ldr_addr = 10'd12;
        for (int k = 0; k < 3; k++) begin
            #3;
            chk("t6_pre_ldr_gnt", 32'(ldr_gnt), 32'd0);
            chk("t6_pre_wait_cnt", 32'(dut.u_starve.r_cnt), 32'(k));
            cpu_q.push_back(32'd11);
            step();
        end
        ldr_req = 1'b0;
        #3;
        chk("t6_drop_wait_cnt", 32'(dut.u_starve.r_cnt), 32'd3);
        chk("t6_drop_ldr_gnt", 32'(ldr_gnt), 32'd0);
        cpu_q.push_back(32'd11);
        step();
        ldr_req = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #3;
            chk("t6_ldr_gnt", 32'(ldr_gnt), 32'(k == 4));
            chk("t6_cpu_stall", 32'(cpu_stall), 32'(k == 4));
            chk("t6_wait_cnt", 32'(dut.u_starve.r_cnt), 32'(k));
            if (k == 4) ldr_q.push_back(32'd12);
            else        cpu_q.push_back(32'd11);
            step();
        end
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        step();
        step();

        // Every expected return must have been consumed
        #3;
        chk("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        chk("ldr_q_drained", 32'(ldr_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
